// File: rtl/rot_reset_ctrl_if.sv
// Signal bundle between the RoT monitors / CPU observation side (master) and the
// reset controller (slave).
interface rot_reset_ctrl_if #(
   parameter int NREQ = 4
);
   // Handshake: req is a level, sampled every cycle while the controller is idle.
   // There is no per-request ready; busy high means a request is being serviced and
   // further req activity is ignored until busy falls.
   logic [NREQ-1:0] req;
   logic [15:0]     pc;
   logic            clr_cause;
   logic            sys_rst;
   logic            busy;
   logic [NREQ-1:0] cause;
   logic [7:0]      viol_cnt;
   logic [1:0]      dbg_state;  // 0 IDLE, 1 HOLD, 2 WAIT

   modport master (
      output req, pc, clr_cause,
      input  sys_rst, busy, cause, viol_cnt, dbg_state
   );

   modport slave (
      input  req, pc, clr_cause,
      output sys_rst, busy, cause, viol_cnt, dbg_state
   );
endinterface

// File: rtl/rot_reset_ctrl.sv
// Turns the first RoT monitor violation into a fixed-length CPU reset pulse, then waits
// for the core to reach its reset handler before re-arming. Keeps cause and count.
module rot_reset_ctrl #(
   parameter int          NREQ          = 4,
   parameter int          HOLD_CYCLES   = 16,
   parameter int          TIMEOUT       = 1024,
   parameter logic [15:0] RESET_HANDLER = 16'hFFFE
) (
   input  logic             clk,
   input  logic             reset_n,
   rot_reset_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_WAIT = 2'd2
   } state_e;

   localparam logic [7:0]  HOLD_INIT = 8'(HOLD_CYCLES - 1);
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_e          state_q, state_d;
   logic            sys_rst_q, sys_rst_d;
   logic            busy_q, busy_d;
   logic [NREQ-1:0] cause_q, cause_d;
   logic [7:0]      viol_cnt_q, viol_cnt_d;
   logic [7:0]      hold_cnt_q, hold_cnt_d;
   logic [15:0]     wait_cnt_q, wait_cnt_d;
   logic            seen_q, seen_d;

   logic req_any;
   logic pc_hit;

   assign req_any = |bus.req;
   assign pc_hit  = (bus.pc == RESET_HANDLER);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         sys_rst_q  <= 1'b0;
         busy_q     <= 1'b0;
         cause_q    <= '0;
         viol_cnt_q <= '0;
         hold_cnt_q <= '0;
         wait_cnt_q <= '0;
         seen_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sys_rst_q  <= sys_rst_d;
         busy_q     <= busy_d;
         cause_q    <= cause_d;
         viol_cnt_q <= viol_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         seen_q     <= seen_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sys_rst_d  = sys_rst_q;
      cause_d    = cause_q;
      viol_cnt_d = viol_cnt_q;
      hold_cnt_d = hold_cnt_q;
      wait_cnt_d = wait_cnt_q;
      seen_d     = seen_q;

      if (bus.clr_cause) begin
         cause_d = '0;
      end

      case (state_q)
         S_IDLE: begin
            if (req_any) begin
               state_d    = S_HOLD;
               sys_rst_d  = 1'b1;
               hold_cnt_d = HOLD_INIT;
               if (viol_cnt_q != 8'hFF) begin
                  viol_cnt_d = viol_cnt_q + 8'd1;
               end
               // Only the first cause is kept, but a capture beats a same-cycle clear.
               if ((cause_q == '0) || bus.clr_cause) begin
                  cause_d = bus.req;
               end
            end
         end
         S_HOLD: begin
            if (hold_cnt_q == 8'd0) begin
               state_d    = S_WAIT;
               sys_rst_d  = 1'b0;
               wait_cnt_d = '0;
               seen_d     = 1'b0;
            end else begin
               hold_cnt_d = hold_cnt_q - 8'd1;
            end
         end
         S_WAIT: begin
            seen_d = seen_q | pc_hit;
            // Monitors lag the core by a cycle, so the handler hit may precede req dropping.
            if ((seen_q || pc_hit) && !req_any) begin
               state_d = S_IDLE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d    = S_HOLD;
               sys_rst_d  = 1'b1;
               hold_cnt_d = HOLD_INIT;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
         default: begin
            state_d   = S_IDLE;
            sys_rst_d = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_comb begin
      bus.sys_rst   = sys_rst_q;
      bus.busy      = busy_q;
      bus.cause     = cause_q;
      bus.viol_cnt  = viol_cnt_q;
      bus.dbg_state = state_q;
   end

endmodule

// File: tb/tb_rot_reset_ctrl.sv
// Randomized scoreboard bench for rot_reset_ctrl: a driver issues violation/reboot
// sequences and a negedge monitor checks reset pulses and re-arm events.
module tb_rot_reset_ctrl;

   localparam int          NREQ  = 4;
   localparam int          HOLD  = 16;
   localparam int          TMO   = 8;
   localparam int          N_SEQ = 300;
   localparam logic [15:0] RH    = 16'hFFFE;
   localparam int          EW    = 32 + NREQ + 8;
   localparam int          BW    = 32 + NREQ;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   rot_reset_ctrl_if #(.NREQ(NREQ)) bus ();

   rot_reset_ctrl #(
      .NREQ(NREQ),
      .HOLD_CYCLES(HOLD),
      .TIMEOUT(TMO),
      .RESET_HANDLER(RH)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   // ---------------- scoreboard state ----------------
   int vectors = 0;
   int errors  = 0;
   bit mon_en  = 1'b0;

   logic [EW-1:0] exp_q[$];    // {rise cycle, cause, viol_cnt} per sys_rst rising edge
   logic [BW-1:0] bfall_q[$];  // {fall cycle, cause} per busy falling edge

   logic [NREQ-1:0] cause_m;
   int              cnt_m;

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   logic prev_rst  = 1'b0;
   logic prev_busy = 1'b0;
   int   width     = 0;

   always @(negedge clk) begin : monitor
      logic [EW-1:0] e;
      logic [BW-1:0] b;
      if (mon_en) begin
         if (bus.sys_rst && !prev_rst) begin
            if (exp_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL unexpected_rst_rise: got rise at cycle %0d expected none", cyc);
            end else begin
               e = exp_q.pop_front();
               check("rst_rise_cycle", cyc, e[EW-1 -: 32]);
               check("cause_at_rise", bus.cause, e[8 +: NREQ]);
               check("viol_cnt_at_rise", bus.viol_cnt, e[7:0]);
               check("busy_at_rise", bus.busy, 1);
            end
         end
         if (!bus.sys_rst && prev_rst) begin
            check("rst_width", width, HOLD);
         end
         if (!bus.busy && prev_busy) begin
            if (bfall_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL unexpected_busy_fall: got fall at cycle %0d expected none", cyc);
            end else begin
               b = bfall_q.pop_front();
               check("busy_fall_cycle", cyc, b[BW-1 -: 32]);
               check("cause_at_rearm", bus.cause, b[NREQ-1:0]);
               check("rst_low_at_rearm", bus.sys_rst, 0);
            end
         end
      end
      if (bus.sys_rst) width <= prev_rst ? width + 1 : 1;
      prev_rst  <= bus.sys_rst;
      prev_busy <= bus.busy;
   end

   // ---------------- driver tasks ----------------
   function automatic logic [15:0] rnd_pc();
      logic [15:0] p;
      p = 16'($urandom);
      if (p == RH) p = 16'h0000;
      return p;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rst(input logic lvl, input string name);
      int n = 0;
      while (bus.sys_rst !== lvl && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) check(name, bus.sys_rst, lvl);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.busy !== 1'b0 && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) check("wait_idle_timeout", bus.busy, 0);
   endtask

   // One violation, optional timeout re-pulse, then the reboot handshake.
   task automatic run_seq(input int it);
      logic [NREQ-1:0] r;
      bit pre_clr, co_clr, tmo, var_a, hs_clr;
      int d, f;
      logic [NREQ-1:0] dir_req [5];
      dir_req[0] = 4'b0001;
      dir_req[1] = 4'b0100;
      dir_req[2] = 4'b0110;
      dir_req[3] = 4'b1010;
      dir_req[4] = 4'b0010;

      r       = NREQ'($urandom_range(1, 15));
      pre_clr = ($urandom_range(0, 7) == 0);
      co_clr  = ($urandom_range(0, 7) == 0);
      tmo     = ($urandom_range(0, 5) == 0);
      var_a   = ($urandom_range(0, 1) == 1);
      hs_clr  = ($urandom_range(0, 7) == 0);
      d       = $urandom_range(0, TMO - 2);
      if (it < 5) begin
         r       = dir_req[it];
         pre_clr = (it == 3);
         co_clr  = (it == 4);
         tmo     = (it == 2);
         hs_clr  = 1'b0;
         var_a   = (it != 2);
      end

      wait_idle();
      bus.pc = rnd_pc();
      if (pre_clr) begin
         bus.clr_cause = 1'b1;
         cause_m = '0;
         step();
         bus.clr_cause = 1'b0;
      end

      bus.req       = r;
      bus.clr_cause = co_clr;
      if (cnt_m < 255) cnt_m++;
      if (cause_m == '0 || co_clr) cause_m = r;
      exp_q.push_back({32'(cyc + 1), cause_m, 8'(cnt_m)});
      step();
      bus.clr_cause = 1'b0;

      // Requests while the pulse is held must be ignored.
      repeat (8) begin
         bus.req = NREQ'($urandom);
         step();
      end
      bus.req = '0;

      wait_rst(1'b0, "rst_fall_timeout");
      f = cyc;
      if (tmo) begin
         exp_q.push_back({32'(f + TMO), cause_m, 8'(cnt_m)});
         wait_rst(1'b1, "tmo_rise_timeout");
         wait_rst(1'b0, "tmo_fall_timeout");
      end

      for (int k = 0; k < d; k++) begin
         bus.pc = rnd_pc();
         step();
      end
      bus.pc        = RH;
      bus.req       = var_a ? NREQ'($urandom_range(1, 15)) : '0;
      bus.clr_cause = hs_clr;
      if (hs_clr) cause_m = '0;
      bfall_q.push_back({32'(cyc + (var_a ? 2 : 1)), cause_m});
      step();
      bus.pc        = rnd_pc();
      bus.req       = '0;
      bus.clr_cause = 1'b0;
   endtask

   // ---------------- main stimulus ----------------
   initial begin
      bus.req       = '0;
      bus.pc        = 16'h0000;
      bus.clr_cause = 1'b0;
      cause_m       = '0;
      cnt_m         = 0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_sys_rst", bus.sys_rst, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_cause", bus.cause, 0);
      check("reset_viol_cnt", bus.viol_cnt, 0);
      check("reset_state", bus.dbg_state, 0);

      reset_n = 1'b1;
      step();
      mon_en = 1'b1;

      for (int it = 0; it < N_SEQ && errors < 20; it++) begin
         run_seq(it);
      end
      wait_idle();
      step();
      check("saturated_viol_cnt", bus.viol_cnt, 255);

      // Asynchronous reset in the middle of a pulse.
      mon_en  = 1'b0;
      bus.req = NREQ'(4'b0001);
      step();
      bus.req = '0;
      wait_rst(1'b1, "arst_rise_timeout");
      repeat (5) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_sys_rst", bus.sys_rst, 0);
      check("arst_busy", bus.busy, 0);
      check("arst_cause", bus.cause, 0);
      check("arst_viol_cnt", bus.viol_cnt, 0);
      check("arst_state", bus.dbg_state, 0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      step();
      check("post_arst_state", bus.dbg_state, 0);
      check("post_arst_rst", bus.sys_rst, 0);
      cause_m = '0;
      cnt_m   = 0;
      mon_en  = 1'b1;
      run_seq(99);
      wait_idle();
      repeat (3) step();

      check("exp_q_drained", exp_q.size(), 0);
      check("bfall_q_drained", bfall_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/rot_reset_ctrl.md
# rot_reset_ctrl

Consumer end of the RoT monitor reset requests: collects violation requests from the active RoT monitors (atomicity, access control, etc.), turns the first one into a fixed-length system reset pulse to the MCU core, and then waits for the core to re-enter the reset handler before re-arming. It records which monitor fired and how many violations have occurred, for the attestation report. It sits between the monitor outputs and the CPU reset input inside the active RoT module.

## Interface
Parameters:
- NREQ, 4, number of monitor request inputs
- HOLD_CYCLES, 16, sys_rst high time in cycles (legal 1..255)
- TIMEOUT, 1024, max cycles in WAIT before re-asserting reset (legal 1..65535)
- RESET_HANDLER, 16'hFFFE, PC value that proves the core has rebooted

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  NREQ  level violation requests from the monitors, active high
- pc  in  16  current CPU program counter
- clr_cause  in  1  single-cycle pulse; clears cause
- sys_rst  out  1  registered reset to the CPU, active high
- busy  out  1  high whenever state is not IDLE
- cause  out  NREQ  sticky first-violation cause bits
- viol_cnt  out  8  saturating violation counter

## Operation
- Reset (reset_n low, async): state IDLE, sys_rst 0, busy 0, cause 0, viol_cnt 0, hold_cnt 0, wait_cnt 0, seen 0.
- States: IDLE, HOLD, WAIT.
- IDLE: if |req, then:
  - go to HOLD.
  - Set sys_rst=1 and hold_cnt=HOLD_CYCLES-1.
  - viol_cnt += 1, saturating at 255.
  - If cause==0, cause <= req; otherwise cause is unchanged (first cause only).
- HOLD: sys_rst stays 1. req is ignored.
  - If hold_cnt==0: go to WAIT, set sys_rst=0, wait_cnt=0, seen=0.
  - Otherwise decrement hold_cnt.
- WAIT: sys_rst is 0.
  - seen is set on any cycle with pc==RESET_HANDLER and stays set.
  - Exit to IDLE when the registered seen is 1, or pc==RESET_HANDLER this cycle, AND req==0 in the same cycle.
  - This tolerates the one-cycle lag of the monitor outputs after the core reaches the handler.
  - Otherwise wait_cnt increments. If wait_cnt reaches TIMEOUT-1 without exiting, return to HOLD: sys_rst=1, hold_cnt=HOLD_CYCLES-1. viol_cnt and cause are not changed by a timeout.
- Requests arriving in HOLD or WAIT are never counted and never trigger a new sequence. A req still high on the IDLE re-entry cycle cannot occur, because exit requires req==0.
- clr_cause clears cause in any state. If clr_cause and a capture happen in the same cycle, the capture wins (cause <= req).
- busy = (state != IDLE), registered together with state.

## Timing
- req first high at edge N, sampled in IDLE: sys_rst, busy and viol_cnt update at edge N+1 (1-cycle latency).
- sys_rst is high for exactly HOLD_CYCLES cycles, then low. From a timeout it is again high for exactly HOLD_CYCLES cycles.
- If pc==RESET_HANDLER and req==0 at edge M in WAIT, busy falls at edge M+1. A new req at edge M+1 is then accepted.
- Simultaneous bits in req at capture are all recorded in cause.
- reset_n asserted mid-sequence forces sys_rst low immediately (async) and clears all state. No pulse is completed.

## Test plan
- Single request: NREQ=4, HOLD_CYCLES=16. Pulse req=4'b0001 in IDLE -> sys_rst high 1 cycle later for exactly 16 cycles; cause=4'b0001; viol_cnt=1; busy high.
- Reboot handshake: after HOLD, hold req=1 and pc=16'hFFFE for 1 cycle, then req=0 -> state returns to IDLE one cycle after req drops; a second req=4'b0100 then gives viol_cnt=2 and cause still 4'b0001.
- Timeout: TIMEOUT=8; never drive pc=16'hFFFE in WAIT -> sys_rst re-asserts after 8 WAIT cycles for HOLD_CYCLES cycles; viol_cnt unchanged.
- Simultaneous and clear: req=4'b1010 from IDLE with cause=0 -> cause=4'b1010. A later clr_cause pulse -> cause=0. clr_cause coincident with a new capture of req=4'b0010 -> cause=4'b0010.
- Saturation: 300 complete violation/reboot sequences -> viol_cnt stops at 255.
- Async reset: drop reset_n at HOLD cycle 5 -> sys_rst, busy, cause and viol_cnt are 0 before the next clk edge; state is IDLE after reset_n releases.
